// File: rtl/flag_ctrl.sv
// Status flag register write sequencer: arbitrates pop-restore, software loads and
// ALU updates, keeps an interrupt save stack, and evaluates branch conditions.
module flag_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             s_reset,
   input  logic             alu_upd,
   input  logic [3:0]       alu_flags,
   input  logic             sw_wr,
   input  logic [3:0]       sw_flags,
   input  logic             push,
   input  logic             pop,
   input  logic [3:0]       fr_q,
   output logic             fr_ce,
   output logic [3:0]       fr_d,
   input  logic             cond_req,
   input  logic [3:0]       cond_sel,
   output logic             cond_ack,
   output logic             cond_true,
   output logic [PTR_W:0]   stk_cnt,
   output logic             ovf_err,
   output logic             unf_err,
   input  logic             err_clr
);

   logic [3:0]     stk_q [DEPTH];
   logic [3:0]     stk_d [DEPTH];
   logic [PTR_W:0] stk_cnt_q, stk_cnt_d;
   logic           fr_ce_q, fr_ce_d;
   logic [3:0]     fr_d_q, fr_d_d;
   logic           cond_ack_q, cond_ack_d;
   logic           cond_true_q, cond_true_d;
   logic           ovf_err_q, ovf_err_d;
   logic           unf_err_q, unf_err_d;

   logic           full, empty, push_ok, pop_ok, ovf_set, unf_set;
   logic [PTR_W:0] cnt_m1;
   logic           f_z, f_s, f_c, f_v, eval;

   always_comb begin
      full    = (stk_cnt_q == (PTR_W+1)'(DEPTH));
      empty   = (stk_cnt_q == '0);
      cnt_m1  = stk_cnt_q - 1'b1;
      // push and pop together cancel each other out entirely, errors included
      push_ok = push & ~pop & ~full;
      pop_ok  = pop & ~push & ~empty;
      ovf_set = push & ~pop & full;
      unf_set = pop & ~push & empty;

      stk_d = stk_q;
      if (push_ok) stk_d[stk_cnt_q[PTR_W-1:0]] = fr_q;

      stk_cnt_d = stk_cnt_q;
      if (push_ok)     stk_cnt_d = stk_cnt_q + 1'b1;
      else if (pop_ok) stk_cnt_d = cnt_m1;

      fr_ce_d = pop_ok | sw_wr | alu_upd;
      fr_d_d  = fr_d_q;
      if (pop_ok)       fr_d_d = stk_q[cnt_m1[PTR_W-1:0]];
      else if (sw_wr)   fr_d_d = sw_flags;
      else if (alu_upd) fr_d_d = alu_flags;

      ovf_err_d = ovf_set | (ovf_err_q & ~err_clr);
      unf_err_d = unf_set | (unf_err_q & ~err_clr);
   end

   always_comb begin
      {f_z, f_s, f_c, f_v} = fr_q;
      case (cond_sel)
         4'd0:    eval = 1'b1;
         4'd1:    eval = f_z;
         4'd2:    eval = ~f_z;
         4'd3:    eval = f_c;
         4'd4:    eval = ~f_c;
         4'd5:    eval = f_s;
         4'd6:    eval = ~f_s;
         4'd7:    eval = f_v;
         4'd8:    eval = ~f_v;
         4'd9:    eval = f_c & ~f_z;
         4'd10:   eval = ~f_c | f_z;
         4'd11:   eval = (f_s == f_v);
         4'd12:   eval = (f_s != f_v);
         4'd13:   eval = ~f_z & (f_s == f_v);
         4'd14:   eval = f_z | (f_s != f_v);
         default: eval = 1'b0;
      endcase
      cond_ack_d  = cond_req;
      cond_true_d = cond_req & eval;
   end

   always_ff @(posedge clk) begin
      if (s_reset) begin
         stk_cnt_q   <= '0;
         fr_ce_q     <= 1'b0;
         fr_d_q      <= 4'b0;
         cond_ack_q  <= 1'b0;
         cond_true_q <= 1'b0;
         ovf_err_q   <= 1'b0;
         unf_err_q   <= 1'b0;
      end else begin
         stk_cnt_q   <= stk_cnt_d;
         fr_ce_q     <= fr_ce_d;
         fr_d_q      <= fr_d_d;
         cond_ack_q  <= cond_ack_d;
         cond_true_q <= cond_true_d;
         ovf_err_q   <= ovf_err_d;
         unf_err_q   <= unf_err_d;
      end
   end

   // stack contents are don't-care after reset, so no reset term here
   always_ff @(posedge clk) begin
      stk_q <= stk_d;
   end

   assign fr_ce     = fr_ce_q;
   assign fr_d      = fr_d_q;
   assign cond_ack  = cond_ack_q;
   assign cond_true = cond_true_q;
   assign stk_cnt   = stk_cnt_q;
   assign ovf_err   = ovf_err_q;
   assign unf_err   = unf_err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: a behavioural model queues the expected outputs
// for each driven cycle, which are compared one cycle later.
module tb_flag_ctrl;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic clk = 1'b0;
   logic s_reset, alu_upd, sw_wr, push, pop, cond_req, err_clr;
   logic [3:0] alu_flags, sw_flags, cond_sel, fr_q, fr_d;
   logic fr_ce, cond_ack, cond_true, ovf_err, unf_err;
   logic [PTR_W:0] stk_cnt;

   always #5 clk = ~clk;

   flag_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .s_reset(s_reset), .alu_upd(alu_upd), .alu_flags(alu_flags),
      .sw_wr(sw_wr), .sw_flags(sw_flags), .push(push), .pop(pop), .fr_q(fr_q),
      .fr_ce(fr_ce), .fr_d(fr_d), .cond_req(cond_req), .cond_sel(cond_sel),
      .cond_ack(cond_ack), .cond_true(cond_true), .stk_cnt(stk_cnt),
      .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
   );

   // the flag register itself lives in the environment
   always @(posedge clk) begin
      if (s_reset)    fr_q <= 4'b0;
      else if (fr_ce) fr_q <= fr_d;
   end

   typedef struct packed {
      logic           ce;
      logic [3:0]     d;
      logic           ack;
      logic           tru;
      logic [PTR_W:0] cnt;
      logic           ovf;
      logic           unf;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] m_stk[$];
   logic [3:0] m_fr = 4'b0;
   logic [3:0] m_d = 4'b0;
   logic       m_ce = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // odd codes test a base predicate, the following even code its inverse
   function automatic logic cond_model(input logic [3:0] f, input logic [3:0] sel);
      logic z, s, c, v, base;
      z = f[3]; s = f[2]; c = f[1]; v = f[0];
      if (sel == 4'd0)  return 1'b1;
      if (sel == 4'd15) return 1'b0;
      case ((sel + 4'd1) >> 1)
         4'd1:    base = z;
         4'd2:    base = c;
         4'd3:    base = s;
         4'd4:    base = v;
         4'd5:    base = c && !z;
         4'd6:    base = (s ~^ v);
         default: base = !z && (s ~^ v);
      endcase
      return sel[0] ? base : !base;
   endfunction

   task automatic step(input bit rst, input bit alu, input logic [3:0] af,
                       input bit sw, input logic [3:0] sf, input bit ps, input bit pp,
                       input bit cr, input logic [3:0] cs, input bit ec);
      exp_t e, got;
      bit ovf_set, unf_set;
      @(negedge clk);
      s_reset = rst; alu_upd = alu; alu_flags = af; sw_wr = sw; sw_flags = sf;
      push = ps; pop = pp; cond_req = cr; cond_sel = cs; err_clr = ec;
      ovf_set = 0; unf_set = 0;
      if (rst) begin
         e = '0;
         m_stk.delete();
         m_ovf = 0; m_unf = 0;
      end else begin
         e.ce = 0; e.d = m_d;
         if (pp && !ps && m_stk.size() > 0) begin
            e.d = m_stk.pop_back(); e.ce = 1;
         end else begin
            if (pp && !ps) unf_set = 1;
            if (sw) begin e.d = sf; e.ce = 1; end
            else if (alu) begin e.d = af; e.ce = 1; end
         end
         if (ps && !pp) begin
            if (m_stk.size() == DEPTH) ovf_set = 1;
            else m_stk.push_back(m_fr);
         end
         m_ovf = ovf_set || (m_ovf && !ec);
         m_unf = unf_set || (m_unf && !ec);
         e.ack = cr;
         e.tru = cr && cond_model(m_fr, cs);
         e.cnt = (PTR_W+1)'(m_stk.size());
         e.ovf = m_ovf; e.unf = m_unf;
      end
      exp_q.push_back(e);
      if (rst)       m_fr = 4'b0;
      else if (m_ce) m_fr = m_d;
      m_ce = e.ce; m_d = e.d;
      @(posedge clk); #1;
      got = exp_q.pop_front();
      chk("fr_ce",     8'(fr_ce),     8'(got.ce));
      chk("fr_d",      8'(fr_d),      8'(got.d));
      chk("cond_ack",  8'(cond_ack),  8'(got.ack));
      chk("cond_true", 8'(cond_true), 8'(got.tru));
      chk("stk_cnt",   8'(stk_cnt),   8'(got.cnt));
      chk("ovf_err",   8'(ovf_err),   8'(got.ovf));
      chk("unf_err",   8'(unf_err),   8'(got.unf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
   endtask

   initial begin
      s_reset = 1; alu_upd = 0; alu_flags = 0; sw_wr = 0; sw_flags = 0;
      push = 0; pop = 0; cond_req = 0; cond_sel = 0; err_clr = 0;
      // reset overrides a concurrent ALU update and condition request
      step(1, 1, 4'hF, 0, 4'h0, 0, 0, 1, 4'h0, 0);
      idle(1);
      // priority: software load beats ALU, then ALU alone
      step(0, 1, 4'b1010, 1, 4'b0101, 0, 0, 0, 4'h0, 0);
      step(0, 1, 4'b1010, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      // save/restore
      step(0, 0, 4'h0, 1, 4'b1100, 0, 0, 0, 4'h0, 0);
      idle(2);
      step(0, 1, 4'b0011, 0, 4'h0, 1, 0, 0, 4'h0, 0);
      idle(2);
      step(0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
      idle(2);
      // overflow with five pushes, flags changing in between
      for (int i = 0; i < 5; i++) step(0, 1, 4'(i + 3), 0, 4'h0, 1, 0, 0, 4'h0, 0);
      idle(1);
      for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
      // underflow: lower-priority ALU write still accepted
      step(0, 1, 4'b0001, 0, 4'h0, 0, 1, 0, 4'h0, 0);
      step(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 1);
      // clear racing a new underflow: set wins
      step(0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 1);
      step(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 1);
      // push+pop together at depth 2
      step(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0);
      step(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0, 0);
      step(0, 0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0, 0);
      step(0, 0, 4'h0, 1, 4'b1001, 1, 1, 0, 4'h0, 0);
      // conditions on z0 s1 c1 ovr0, back to back
      step(0, 0, 4'h0, 1, 4'b0110, 0, 0, 0, 4'h0, 0);
      idle(2);
      step(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'd11, 0);
      step(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'd12, 0);
      // request concurrent with a write sees the old flags
      step(0, 1, 4'b1000, 0, 4'h0, 0, 0, 1, 4'd9, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 4'(i), 0);
      // reset mid-restore with pending request
      step(0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
      step(1, 0, 4'h0, 0, 4'h0, 0, 1, 1, 4'h0, 0);
      idle(1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 0, 4'($urandom),
              $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, 4'($urandom),
              $urandom_range(0, 15) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
